// File: rtl/count_bcd_converter.sv
// count_bcd_converter: two-channel sequential double-dabble binary-to-BCD converter with periodic refresh (optional blank masks via BCD_BLANK_EN)
module count_bcd_converter #(
  parameter int WIDTH          = 32,
  parameter int DIGITS         = 10,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      bin_a,
  input  logic [WIDTH-1:0]      bin_b,
  input  logic                  force_upd,
  output logic [4*DIGITS-1:0]   bcd_a,
  output logic [4*DIGITS-1:0]   bcd_b,
  output logic                  busy,
  output logic                  upd,
  output logic [DIGITS-1:0]     blank_a,
  output logic [DIGITS-1:0]     blank_b
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(REFRESH_CYCLES);
  typedef enum logic [2:0] {IDLE, LOAD_A, SHIFT_A, STORE_A, LOAD_B, SHIFT_B, STORE_B} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0] scratch, adj;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic wrap, req, last;
  assign wrap = rcnt == RW'(REFRESH_CYCLES - 1);
  assign req  = force_upd | wrap;
  assign last = cnt == CW'(WIDTH - 1);
  // add 3 to every scratch digit that is 5 or more before the shift
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = scratch[4*i+:4] >= 4'd5 ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
  end
  // next-state sequencing: channel A pass then channel B pass
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req ? LOAD_A : IDLE;
      LOAD_A:  state_n = SHIFT_A;
      SHIFT_A: state_n = last ? STORE_A : SHIFT_A;
      STORE_A: state_n = LOAD_B;
      LOAD_B:  state_n = SHIFT_B;
      SHIFT_B: state_n = last ? STORE_B : SHIFT_B;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // refresh counter runs freely and wraps every REFRESH_CYCLES
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rcnt <= '0;
    else rcnt <= wrap ? '0 : rcnt + RW'(1);
  // conversion datapath, output banks and status flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_a   <= '0;
      bcd_b   <= '0;
      busy    <= 1'b0;
      upd     <= 1'b0;
    end else begin
      upd <= state == STORE_B;
      if (state == IDLE && req) busy <= 1'b1;
      if (state == STORE_B) busy <= 1'b0;
      if (state == LOAD_A || state == LOAD_B) begin
        shreg   <= state == LOAD_A ? bin_a : bin_b;
        scratch <= '0;
        cnt     <= '0;
      end
      if (state == SHIFT_A || state == SHIFT_B) begin
        scratch <= {adj[BW-2:0], shreg[WIDTH-1]};
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        cnt     <= cnt + CW'(1);
      end
      if (state == STORE_A) bcd_a <= scratch;
      if (state == STORE_B) bcd_b <= scratch;
    end
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blk;
  logic z;
  // digit i is blank when it and every higher digit are zero; units never blank
  always_comb begin
    blk = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z & (scratch[4*i+:4] == 4'd0);
      blk[i] = z;
    end
  end
  // blank masks are captured alongside their digit bank
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      blank_a <= '0;
      blank_b <= '0;
    end else begin
      if (state == STORE_A) blank_a <= blk;
      if (state == STORE_B) blank_b <= blk;
    end
`else
  assign blank_a = '0;
  assign blank_b = '0;
`endif
endmodule
